// File: rtl/y86_mem_arbiter_pkg.sv
// Shared definitions for the y86 memory arbiter: FSM states, master indices
// and default bus widths.
package y86_bus_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    // Master indices, also the encoding of the owner output
    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_e;

    // Select between a CPU-side and a DMA-side one-bit value by master index
    function automatic logic sel_bit(input logic who, input logic cpu_v, input logic dma_v);
        logic r;
        if (who == M_DMA) begin
            r = dma_v;
        end else begin
            r = cpu_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/y86_mem_arbiter_if.sv
// Bundle of both master handshakes and the shared memory bus.
// slave  : the arbiter's view (requests in, grants/responses/bus out)
// master : the environment's view (masters plus memory)
interface y86_mem_arbiter_if
    import y86_bus_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic          m0_err;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic          m1_err;

    logic [DW-1:0] rdata;

    logic [AW-1:0] bus_A;
    logic          bus_RE;
    logic          bus_WE;
    logic [DW-1:0] bus_out;
    logic [DW-1:0] bus_in;
    logic          bus_ready;

    logic          busy;
    logic          owner;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  bus_in, bus_ready,
        output m0_gnt, m0_rvalid, m0_err,
        output m1_gnt, m1_rvalid, m1_err,
        output rdata, bus_A, bus_RE, bus_WE, bus_out, busy, owner
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output bus_in, bus_ready,
        input  m0_gnt, m0_rvalid, m0_err,
        input  m1_gnt, m1_rvalid, m1_err,
        input  rdata, bus_A, bus_RE, bus_WE, bus_out, busy, owner
    );

endinterface

// File: rtl/y86_mem_arbiter_pick.sv
// Winner selection for the two masters. The CPU has fixed priority, but once
// it has been granted MAX_CPU_STREAK times in a row while the DMA master was
// waiting, the DMA master is forced through on the next contested grant.
module y86_arb_pick
    import y86_bus_pkg::*;
#(
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic m0_req,
    input  logic m1_req,
    input  logic grant_en,
    output logic winner,
    output logic any_req
);

    localparam int             SW         = $clog2(MAX_CPU_STREAK + 1);
    localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_CPU_STREAK);

    logic [SW-1:0] streak_r;
    logic          winner_s;
    logic          grant_s;

    assign any_req = m0_req | m1_req;
    assign grant_s = grant_en & any_req;
    assign winner  = winner_s;

    // Pick the winner: sole requester wins, contention goes to the CPU unless starved DMA is due
    always_comb begin
        winner_s = M_CPU;
        if (m0_req && m1_req) begin
            if (streak_r == STREAK_MAX) begin
                winner_s = M_DMA;
            end else begin
                winner_s = M_CPU;
            end
        end else if (m1_req) begin
            winner_s = M_DMA;
        end else begin
            winner_s = M_CPU;
        end
    end

    // Count CPU grants taken while the DMA master waits; any DMA grant or idle DMA clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_r <= {SW{1'b0}};
        end else if (!m1_req) begin
            streak_r <= {SW{1'b0}};
        end else if (grant_s && (winner_s == M_DMA)) begin
            streak_r <= {SW{1'b0}};
        end else if (grant_s && (streak_r != STREAK_MAX)) begin
            streak_r <= streak_r + SW'(1);
        end else begin
            streak_r <= streak_r;
        end
    end

endmodule

// File: rtl/y86_mem_arbiter.sv
// Two-master arbiter for the single y86 memory bus. One access is in flight
// at a time; grants are issued combinationally from IDLE, the bus is driven
// from registers during ACCESS, and completion (or timeout) is reported with
// a one-cycle rvalid pulse to the owning master.
module y86_mem_arbiter
    import y86_bus_pkg::*;
#(
    parameter int AW             = DEF_AW,
    parameter int DW             = DEF_DW,
    parameter int MAX_CPU_STREAK = 4,
    parameter int TIMEOUT_CYC    = 16
) (
    input  logic             clk,
    input  logic             rst,
    y86_mem_arbiter_if.slave mif
);

    localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYC - 1);

    arb_state_e    state_r;
    logic          owner_r;
    logic [TW-1:0] tcnt_r;
    logic [AW-1:0] bus_a_r;
    logic          bus_re_r;
    logic          bus_we_r;
    logic [DW-1:0] bus_out_r;
    logic          rv0_r;
    logic          rv1_r;
    logic          err0_r;
    logic          err1_r;
    logic [DW-1:0] rdata_r;

    logic          winner_s;
    logic          any_req_s;
    logic          grant_en_s;
    logic          grant_s;
    logic          win_we_s;
    logic [AW-1:0] win_addr_s;
    logic [DW-1:0] win_wdata_s;
    logic          done_s;
    logic          timeout_s;

    // Grants are held off while reset is asserted so no gnt leaks out during reset
    assign grant_en_s = rst & (state_r == IDLE);
    assign grant_s    = grant_en_s & any_req_s;

    y86_arb_pick #(
        .MAX_CPU_STREAK(MAX_CPU_STREAK)
    ) u_pick (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (mif.m0_req),
        .m1_req   (mif.m1_req),
        .grant_en (grant_en_s),
        .winner   (winner_s),
        .any_req  (any_req_s)
    );

    // Route the winning master's request fields to the latch inputs
    always_comb begin
        win_we_s    = 1'b0;
        win_addr_s  = {AW{1'b0}};
        win_wdata_s = {DW{1'b0}};
        if (winner_s == M_DMA) begin
            win_we_s    = mif.m1_we;
            win_addr_s  = mif.m1_addr;
            win_wdata_s = mif.m1_wdata;
        end else begin
            win_we_s    = mif.m0_we;
            win_addr_s  = mif.m0_addr;
            win_wdata_s = mif.m0_wdata;
        end
    end

    // An access ends on memory ready, or after TIMEOUT_CYC unanswered cycles
    assign timeout_s = (state_r == ACCESS) && !mif.bus_ready && (tcnt_r == TCNT_LAST);
    assign done_s    = (state_r == ACCESS) && (mif.bus_ready || (tcnt_r == TCNT_LAST));

    // Access FSM: latch the winner's request, drive the bus, report completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            owner_r   <= M_CPU;
            tcnt_r    <= {TW{1'b0}};
            bus_a_r   <= {AW{1'b0}};
            bus_re_r  <= 1'b0;
            bus_we_r  <= 1'b0;
            bus_out_r <= {DW{1'b0}};
            rv0_r     <= 1'b0;
            rv1_r     <= 1'b0;
            err0_r    <= 1'b0;
            err1_r    <= 1'b0;
            rdata_r   <= {DW{1'b0}};
        end else begin
            rv0_r  <= 1'b0;
            rv1_r  <= 1'b0;
            err0_r <= 1'b0;
            err1_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        state_r   <= ACCESS;
                        owner_r   <= winner_s;
                        tcnt_r    <= {TW{1'b0}};
                        bus_a_r   <= win_addr_s;
                        bus_re_r  <= !win_we_s;
                        bus_we_r  <= win_we_s;
                        bus_out_r <= win_we_s ? win_wdata_s : {DW{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (done_s) begin
                        state_r   <= IDLE;
                        bus_a_r   <= {AW{1'b0}};
                        bus_re_r  <= 1'b0;
                        bus_we_r  <= 1'b0;
                        bus_out_r <= {DW{1'b0}};
                        rv0_r     <= sel_bit(owner_r, 1'b1, 1'b0);
                        rv1_r     <= sel_bit(owner_r, 1'b0, 1'b1);
                        err0_r    <= sel_bit(owner_r, timeout_s, 1'b0);
                        err1_r    <= sel_bit(owner_r, 1'b0, timeout_s);
                        rdata_r   <= (timeout_s || bus_we_r) ? {DW{1'b0}} : mif.bus_in;
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bus_a_r   <= {AW{1'b0}};
                    bus_re_r  <= 1'b0;
                    bus_we_r  <= 1'b0;
                    bus_out_r <= {DW{1'b0}};
                end
            endcase
        end
    end

    assign mif.m0_gnt    = grant_s & (winner_s == M_CPU);
    assign mif.m1_gnt    = grant_s & (winner_s == M_DMA);
    assign mif.m0_rvalid = rv0_r;
    assign mif.m1_rvalid = rv1_r;
    assign mif.m0_err    = err0_r;
    assign mif.m1_err    = err1_r;
    assign mif.rdata     = rdata_r;
    assign mif.bus_A     = bus_a_r;
    assign mif.bus_RE    = bus_re_r;
    assign mif.bus_WE    = bus_we_r;
    assign mif.bus_out   = bus_out_r;
    assign mif.busy      = (state_r == ACCESS);
    assign mif.owner     = owner_r;

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Self-checking bench for y86_mem_arbiter: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a transaction model.
module tb_y86_mem_arbiter;
    import y86_bus_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    y86_mem_arbiter_if #(.AW(AW), .DW(DW)) mif ();

    y86_mem_arbiter #(
        .AW(AW), .DW(DW), .MAX_CPU_STREAK(MAXS), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mif (mif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ctl_now();
        return {mif.m0_gnt, mif.m1_gnt, mif.bus_RE, mif.bus_WE,
                mif.m0_rvalid, mif.m1_rvalid, mif.m0_err, mif.m1_err};
    endfunction

    task automatic drive_idle();
        mif.m0_req = 1'b0; mif.m0_we = 1'b0; mif.m0_addr = 32'h0; mif.m0_wdata = 32'h0;
        mif.m1_req = 1'b0; mif.m1_we = 1'b0; mif.m1_addr = 32'h0; mif.m1_wdata = 32'h0;
        mif.bus_ready = 1'b0; mif.bus_in = 32'h0;
    endtask

    // ctl = {m0_gnt, m1_gnt, bus_RE, bus_WE, m0_rvalid, m1_rvalid, m0_err, m1_err}
    typedef struct {
        logic r0, w0; logic [31:0] a0, d0;
        logic r1, w1; logic [31:0] a1, d1;
        logic rdy;    logic [31:0] bin;
        logic [7:0] ctl; logic [31:0] ba, bo, rd;
    } vec_t;

    function automatic vec_t mk(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                                input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                                input logic rdy, input logic [31:0] bin, input logic [7:0] ctl,
                                input logic [31:0] ba, input logic [31:0] bo, input logic [31:0] rd);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.rdy = rdy; v.bin = bin; v.ctl = ctl; v.ba = ba; v.bo = bo; v.rd = rd;
        return v;
    endfunction

    // Reference arbitration decision from the priority/starvation rule
    function automatic int model_pick(input bit r0, input bit r1, input int streak);
        if (r0 && r1) return (streak >= MAXS) ? 1 : 0;
        return r1 ? 1 : 0;
    endfunction

    vec_t vt[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int order[$];
        int exp_order[10];
        bit pend;
        int seen, re_cycles, spurious, cnt_g0, cnt_g1, cnt_rv0, cnt_rv1, cnt_e1;

        drive_idle();
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- reset state ----------------
        check("reset.ctl", ctl_now(), 8'h00);
        check("reset.busy_owner", {mif.busy, mif.owner}, 2'b00);
        check("reset.bus_A", mif.bus_A, 32'h0);
        check("reset.bus_out", mif.bus_out, 32'h0);
        check("reset.rdata", mif.rdata, 32'h0);
        mif.m0_req = 1'b1;
        #1 check("reset.gnt_blocked", {mif.m0_gnt, mif.m1_gnt}, 2'b00);
        mif.m0_req = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // ---------------- vector table: M0 read, then M1 write with 3 waits ----------------
        vt[0] = mk(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        8'b1000_0000, 32'h0,   32'h0,        32'h0);
        vt[1] = mk(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF, 8'b0010_0000, 32'h100, 32'h0,        32'h0);
        vt[2] = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        8'b0000_1000, 32'h0,   32'h0,        32'hDEADBEEF);
        vt[3] = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        8'b0000_0000, 32'h0,   32'h0,        32'hDEADBEEF);
        vt[4] = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0, 32'h0, 8'b0100_0000, 32'h0,  32'h0,        32'hDEADBEEF);
        vt[5] = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 1'b0, 32'hFFF, 32'h0, 1'b0, 32'h0,      8'b0001_0000, 32'h40,  32'h12345678, 32'hDEADBEEF);
        vt[6] = vt[5];
        vt[7] = vt[5];
        vt[8] = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 1'b0, 32'hFFF, 32'h0, 1'b1, 32'hAAAA5555, 8'b0001_0000, 32'h40, 32'h12345678, 32'hDEADBEEF);
        vt[9] = mk(1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,        8'b0000_0100, 32'h0,   32'h0,        32'h0);

        for (int i = 0; i < 10; i++) begin
            mif.m0_req = vt[i].r0; mif.m0_we = vt[i].w0; mif.m0_addr = vt[i].a0; mif.m0_wdata = vt[i].d0;
            mif.m1_req = vt[i].r1; mif.m1_we = vt[i].w1; mif.m1_addr = vt[i].a1; mif.m1_wdata = vt[i].d1;
            mif.bus_ready = vt[i].rdy; mif.bus_in = vt[i].bin;
            @(negedge clk);
            check($sformatf("vec%0d.ctl", i), ctl_now(), vt[i].ctl);
            check($sformatf("vec%0d.bus_A", i), mif.bus_A, vt[i].ba);
            check($sformatf("vec%0d.bus_out", i), mif.bus_out, vt[i].bo);
            check($sformatf("vec%0d.rdata", i), mif.rdata, vt[i].rd);
            @(posedge clk); #1;
        end

        // ---------------- both masters saturate the bus: starvation guard order ----------------
        drive_idle();
        mif.m0_req = 1'b1; mif.m0_addr = 32'h1000;
        mif.m1_req = 1'b1; mif.m1_addr = 32'h2000;
        mif.bus_ready = 1'b1; mif.bus_in = 32'hC0DE0000 | 32'($urandom_range(1, 255));
        pend = 1'b0;
        for (int cyc = 0; cyc < 200 && order.size() < 10; cyc++) begin
            @(negedge clk);
            if (mif.m0_rvalid || mif.m1_rvalid)
                check("order.rv_owner", {mif.m1_rvalid, mif.m0_rvalid}, pend ? 2'b10 : 2'b01);
            if (mif.m0_gnt) begin order.push_back(0); pend = 1'b0; end
            else if (mif.m1_gnt) begin order.push_back(1); pend = 1'b1; end
            @(posedge clk); #1;
        end
        mif.m0_req = 1'b0; mif.m1_req = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (mif.m0_rvalid || mif.m1_rvalid) begin
                check("order.tail_owner", {mif.m1_rvalid, mif.m0_rvalid}, pend ? 2'b10 : 2'b01);
                seen++;
            end
        end
        check("order.tail_rv_count", seen, 1);
        check("order.count", order.size(), 10);
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 10; i++)
            check($sformatf("order.grant%0d", i), (i < order.size()) ? order[i] : 9, exp_order[i]);

        // ---------------- timeout on silent memory, pending M1 granted in rvalid cycle ----------------
        @(posedge clk); #1;
        drive_idle();
        mif.m0_req = 1'b1; mif.m0_addr = 32'h200;
        @(negedge clk);
        check("tmo.gnt", {mif.m0_gnt, mif.m1_gnt}, 2'b10);
        @(posedge clk); #1;
        mif.m0_req = 1'b0;
        mif.m1_req = 1'b1; mif.m1_we = 1'b0; mif.m1_addr = 32'h300;
        re_cycles = 0; spurious = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!mif.bus_RE) break;
            re_cycles++;
            if (mif.m1_gnt || mif.m0_rvalid) spurious++;
            @(posedge clk); #1;
        end
        check("tmo.re_cycles", re_cycles, TMO);
        check("tmo.no_early", spurious, 0);
        check("tmo.rv_err", {mif.m0_rvalid, mif.m0_err, mif.m1_rvalid, mif.m1_err}, 4'b1100);
        check("tmo.rdata", mif.rdata, 32'h0);
        check("tmo.m1_gnt_same_cycle", mif.m1_gnt, 1'b1);
        @(posedge clk); #1;
        mif.m1_req = 1'b0; mif.bus_ready = 1'b1; mif.bus_in = 32'h5A5A5A5A;
        @(negedge clk);
        check("tmo.m1_access", {mif.busy, mif.owner, mif.bus_RE}, 3'b111);
        check("tmo.m1_addr", mif.bus_A, 32'h300);
        @(negedge clk);
        check("tmo.m1_rv", {mif.m1_rvalid, mif.m1_err}, 2'b10);
        check("tmo.m1_rdata", mif.rdata, 32'h5A5A5A5A);

        // ---------------- async reset in the middle of an access ----------------
        @(posedge clk); #1;
        mif.bus_ready = 1'b0;
        mif.m1_req = 1'b1; mif.m1_addr = 32'h44;
        @(negedge clk);
        check("rst.gnt", {mif.m0_gnt, mif.m1_gnt}, 2'b01);
        @(posedge clk); #1;
        mif.m1_req = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst.ctl", ctl_now(), 8'h00);
        check("rst.busy_owner", {mif.busy, mif.owner}, 2'b00);
        check("rst.bus_A", mif.bus_A, 32'h0);
        check("rst.rdata", mif.rdata, 32'h0);
        mif.bus_ready = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (mif.m0_rvalid || mif.m1_rvalid) seen++;
        end
        check("rst.no_rvalid", seen, 0);
        @(posedge clk); #1;
        mif.m0_req = 1'b1; mif.m0_addr = 32'h10;
        mif.m1_req = 1'b1; mif.m1_addr = 32'h20;
        @(negedge clk);
        check("rst.first_gnt", {mif.m0_gnt, mif.m1_gnt}, 2'b10);
        @(posedge clk); #1;
        mif.m0_req = 1'b0; mif.m1_req = 1'b0;
        repeat (3) @(negedge clk);

        // ---------------- M0 request withdrawn while M1 owns the bus ----------------
        cnt_g0 = 0; cnt_g1 = 0; cnt_rv0 = 0; cnt_rv1 = 0; cnt_e1 = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            case (k)
                0: begin
                    mif.bus_ready = 1'b0;
                    mif.m1_req = 1'b1; mif.m1_we = 1'b1; mif.m1_addr = 32'h80; mif.m1_wdata = 32'h55;
                end
                1: begin mif.m1_req = 1'b0; mif.m0_req = 1'b1; mif.m0_addr = 32'h90; end
                2: mif.m0_req = 1'b0;
                3: mif.bus_ready = 1'b1;
                default: mif.bus_ready = 1'b1;
            endcase
            @(negedge clk);
            cnt_g0 += int'(mif.m0_gnt);   cnt_g1 += int'(mif.m1_gnt);
            cnt_rv0 += int'(mif.m0_rvalid); cnt_rv1 += int'(mif.m1_rvalid);
            cnt_e1 += int'(mif.m1_err);
        end
        check("drop.m0_gnt", cnt_g0, 0);
        check("drop.m1_gnt", cnt_g1, 1);
        check("drop.m0_rvalid", cnt_rv0, 0);
        check("drop.m1_rvalid", cnt_rv1, 1);
        check("drop.m1_err", cnt_e1, 0);

        // ---------------- randomized traffic against the transaction model ----------------
        @(posedge clk); #1;
        drive_idle();
        rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        begin
            bit m_busy, m_own, m_we, m_rv0, m_rv1, m_e0, m_e1, g0_prev, g1_prev;
            bit e_g0, e_g1, grant, r0, r1;
            int m_age, m_streak, pick;
            logic [31:0] m_addr, m_wdata, m_rdata;
            m_busy = 1'b0; m_own = 1'b0; m_we = 1'b0; m_rv0 = 1'b0; m_rv1 = 1'b0;
            m_e0 = 1'b0; m_e1 = 1'b0; m_age = 0; m_streak = 0;
            m_addr = 32'h0; m_wdata = 32'h0; m_rdata = 32'h0;
            g0_prev = 1'b0; g1_prev = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                @(posedge clk); #1;
                if (mif.m0_req && !g0_prev) mif.m0_req = ($urandom_range(0, 19) != 0);
                else begin
                    mif.m0_req = ($urandom_range(0, 99) < 45);
                    mif.m0_we = ($urandom_range(0, 1) == 1); mif.m0_addr = $urandom; mif.m0_wdata = $urandom;
                end
                if (mif.m1_req && !g1_prev) mif.m1_req = ($urandom_range(0, 19) != 0);
                else begin
                    mif.m1_req = ($urandom_range(0, 99) < 45);
                    mif.m1_we = ($urandom_range(0, 1) == 1); mif.m1_addr = $urandom; mif.m1_wdata = $urandom;
                end
                mif.bus_ready = (((c / 250) % 4) == 3) ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 9) < 6);
                mif.bus_in = $urandom;
                @(negedge clk);

                r0 = mif.m0_req; r1 = mif.m1_req;
                pick  = model_pick(r0, r1, m_streak);
                grant = !m_busy && (r0 || r1);
                e_g0  = grant && (pick == 0);
                e_g1  = grant && (pick == 1);
                check($sformatf("rnd%0d.ctl", c), ctl_now(),
                      {e_g0, e_g1, m_busy && !m_we, m_busy && m_we, m_rv0, m_rv1, m_e0, m_e1});
                check($sformatf("rnd%0d.bus_A", c), mif.bus_A, m_busy ? m_addr : 32'h0);
                check($sformatf("rnd%0d.bus_out", c), mif.bus_out, (m_busy && m_we) ? m_wdata : 32'h0);
                check($sformatf("rnd%0d.rdata", c), mif.rdata, m_rdata);
                check($sformatf("rnd%0d.busy_owner", c), {mif.busy, mif.owner}, {m_busy, m_own});
                g0_prev = mif.m0_gnt; g1_prev = mif.m1_gnt;

                // advance the model by one clock
                m_rv0 = 1'b0; m_rv1 = 1'b0; m_e0 = 1'b0; m_e1 = 1'b0;
                if (m_busy) begin
                    m_age++;
                    if (mif.bus_ready || m_age == TMO) begin
                        if (m_own) begin m_rv1 = 1'b1; m_e1 = !mif.bus_ready; end
                        else       begin m_rv0 = 1'b1; m_e0 = !mif.bus_ready; end
                        m_rdata = (mif.bus_ready && !m_we) ? mif.bus_in : 32'h0;
                        m_busy  = 1'b0;
                    end
                end else if (grant) begin
                    m_busy  = 1'b1;
                    m_own   = (pick == 1);
                    m_we    = m_own ? mif.m1_we : mif.m0_we;
                    m_addr  = m_own ? mif.m1_addr : mif.m0_addr;
                    m_wdata = m_own ? mif.m1_wdata : mif.m0_wdata;
                    m_age   = 0;
                end
                if (!r1) m_streak = 0;
                else if (grant && pick == 1) m_streak = 0;
                else if (grant) m_streak = (m_streak + 1 > MAXS) ? MAXS : m_streak + 1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
